// File: rtl/fft_capture_seq.sv
// fft_capture_seq: runs one FFT capture, then scans a RAM bin window and reports its peak bin.
module fft_capture_seq #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int SCAN_LO = 1900,
    parameter int SCAN_HI = 2100,
    parameter int RD_LAT  = 2,
    parameter int CLR_CYC = 4,
    parameter int TMO_CYC = 1000000,
    parameter int TMO_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_done,
    output logic              wr_clr,
    output logic              fft_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] peak_addr,
    output logic [DATA_W-1:0] peak_mag,
    output logic              result_valid,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, CAPTURE, SCAN, DRAIN, DONE} state_t;
    state_t state;
    logic [TMO_W-1:0] cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
    logic [DATA_W-1:0] max_mag;
    logic [ADDR_W-1:0] max_addr;
    // Tags each returned word with the address that requested it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_en;
            addr_pipe[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_clr       <= 1'b1;
            fft_en       <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            peak_addr    <= '0;
            peak_mag     <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            max_mag      <= '0;
            max_addr     <= '0;
        end else begin
            result_valid <= 1'b0;
            // Strictly greater keeps the lowest address on ties.
            if (vld_pipe[RD_LAT-1] && rd_data > max_mag) begin
                max_mag  <= rd_data;
                max_addr <= addr_pipe[RD_LAT-1];
            end
            case (state)
                IDLE: if (start) begin
                    state       <= CLEAR;
                    busy        <= 1'b1;
                    timeout_err <= 1'b0;
                    cnt         <= '0;
                end
                CLEAR: if (cnt == TMO_W'(CLR_CYC - 1)) begin
                    state  <= CAPTURE;
                    wr_clr <= 1'b0;
                    fft_en <= 1'b1;
                    cnt    <= '0;
                end else cnt <= cnt + 1'b1;
                CAPTURE: if (wr_done) begin
                    state    <= SCAN;
                    fft_en   <= 1'b0;
                    rd_en    <= 1'b1;
                    rd_addr  <= ADDR_W'(SCAN_LO);
                    max_mag  <= '0;
                    max_addr <= ADDR_W'(SCAN_LO);
                end else if (cnt == TMO_W'(TMO_CYC - 1)) begin
                    state       <= IDLE;
                    fft_en      <= 1'b0;
                    wr_clr      <= 1'b1;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                end else cnt <= cnt + 1'b1;
                SCAN: if (rd_addr == ADDR_W'(SCAN_HI)) begin
                    state <= DRAIN;
                    rd_en <= 1'b0;
                    cnt   <= '0;
                end else rd_addr <= rd_addr + 1'b1;
                DRAIN: if (cnt == TMO_W'(RD_LAT - 1)) state <= DONE;
                else cnt <= cnt + 1'b1;
                DONE: begin
                    state        <= IDLE;
                    peak_addr    <= max_addr;
                    peak_mag     <= max_mag;
                    result_valid <= 1'b1;
                    wr_clr       <= 1'b1;
                    busy         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_capture_seq.sv
// tb_fft_capture_seq: scoreboard bench for fft_capture_seq with a latency-modelled RAM.
module tb_fft_capture_seq;
    localparam int ADDR_W = 6, DATA_W = 8, SCAN_LO = 8, SCAN_HI = 15, RD_LAT = 2;
    localparam int CLR_CYC = 4, TMO_CYC = 100, TMO_W = 8;
    localparam int N = SCAN_HI - SCAN_LO + 1;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_done = 1'b0;
    logic wr_clr, fft_en, rd_en, busy, result_valid, timeout_err;
    logic [ADDR_W-1:0] rd_addr, peak_addr;
    logic [DATA_W-1:0] rd_data, peak_mag;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rs [RD_LAT];
    int compared = 0, mismatched = 0, cyc = 0, rv_count = 0, rv_cyc = 0, wd_cyc = 0;
    bit wd_prev = 1'b0;
    int q_addr[$], q_mag[$], rd_seen[$];

    always #5 clk = ~clk;

    fft_capture_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_LO(SCAN_LO), .SCAN_HI(SCAN_HI),
        .RD_LAT(RD_LAT), .CLR_CYC(CLR_CYC), .TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_done(wr_done), .wr_clr(wr_clr),
        .fft_en(fft_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .peak_addr(peak_addr), .peak_mag(peak_mag), .result_valid(result_valid),
        .timeout_err(timeout_err));

    // RAM returns mem[addr] RD_LAT cycles after a read; garbage otherwise.
    assign rd_data = rs[RD_LAT-1];
    always @(posedge clk) begin
        rs[0] <= rd_en ? mem[rd_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) rs[i] <= rs[i-1];
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_peak(output int a, output int m);
        a = SCAN_LO;
        m = 0;
        for (int i = SCAN_LO; i <= SCAN_HI; i++)
            if (int'(mem[i]) > m) begin
                m = int'(mem[i]);
                a = i;
            end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (wr_done && !wd_prev) wd_cyc = cyc;
        wd_prev = wr_done;
        if (rd_en) rd_seen.push_back(int'(rd_addr));
        if (result_valid) begin
            rv_count++;
            rv_cyc = cyc;
            if (q_addr.size() == 0) check("unexpected_result", 1, 0);
            else begin
                check("peak_addr", int'(peak_addr), q_addr.pop_front());
                check("peak_mag", int'(peak_mag), q_mag.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic capture(input int dly, input bit poke);
        int a, m, n0;
        ref_peak(a, m);
        q_addr.push_back(a);
        q_mag.push_back(m);
        n0 = rv_count;
        rd_seen.delete();
        pulse_start();
        check("timeout_err_cleared", int'(timeout_err), 0);
        repeat (CLR_CYC + dly) @(posedge clk);
        #1;
        check("capture_fft_en", int'(fft_en), 1);
        check("capture_wr_clr", int'(wr_clr), 0);
        wr_done = 1'b1;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 200 && rv_count == n0; i++) @(posedge clk);
        check("result_seen", rv_count, n0 + 1);
        // wr_done is first seen half a cycle before the edge that samples it.
        check("latency", rv_cyc - wd_cyc, N + RD_LAT + 2);
        check("rd_count", rd_seen.size(), N);
        for (int i = 0; i < N && i < rd_seen.size(); i++) check("rd_addr", rd_seen[i], SCAN_LO + i);
        @(posedge clk); #1 wr_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("single_result", rv_count, n0 + 1);
        check("idle_busy", int'(busy), 0);
        check("idle_wr_clr", int'(wr_clr), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int fft_cycles, n0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_wr_clr", int'(wr_clr), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_fft_en", int'(fft_en), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_peak_addr", int'(peak_addr), 0);
        check("rst_peak_mag", int'(peak_mag), 0);
        check("rst_result_valid", rv_count, 0);
        check("rst_timeout_err", int'(timeout_err), 0);

        {mem[8], mem[9], mem[10], mem[11]} = {8'd3, 8'd9, 8'd4, 8'd9};
        {mem[12], mem[13], mem[14], mem[15]} = {8'd1, 8'd0, 8'd2, 8'd7};
        capture(50, 1'b0);

        for (int i = SCAN_LO; i <= SCAN_HI; i++) mem[i] = '0;
        capture(7, 1'b0);

        for (int k = 0; k < 6; k++) begin
            for (int i = SCAN_LO; i <= SCAN_HI; i++) mem[i] = DATA_W'($urandom_range(0, 15));
            capture(int'($urandom_range(1, 60)), 1'b0);
        end

        n0 = rv_count;
        fft_cycles = 0;
        pulse_start();
        for (int g = 0; g < 400 && busy; g++) begin
            @(posedge clk); #1;
            if (fft_en) fft_cycles++;
        end
        check("tmo_fft_cycles", fft_cycles, TMO_CYC);
        check("tmo_err", int'(timeout_err), 1);
        check("tmo_fft_en", int'(fft_en), 0);
        check("tmo_busy", int'(busy), 0);
        check("tmo_no_result", rv_count, n0);

        for (int i = SCAN_LO; i <= SCAN_HI; i++) mem[i] = DATA_W'($urandom_range(0, 255));
        capture(5, 1'b0);

        for (int i = SCAN_LO; i <= SCAN_HI; i++) mem[i] = DATA_W'($urandom_range(0, 63));
        capture(20, 1'b1);
        mem[10] = 8'd200;
        capture(3, 1'b0);

        q_addr.push_back(0);
        q_mag.push_back(0);
        pulse_start();
        repeat (CLR_CYC + 2) @(posedge clk);
        #1 wr_done = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_peak_addr", int'(peak_addr), 0);
        check("arst_peak_mag", int'(peak_mag), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_rd_en", int'(rd_en), 0);
        check("arst_rd_addr", int'(rd_addr), 0);
        check("arst_wr_clr", int'(wr_clr), 1);
        void'(q_addr.pop_back());
        void'(q_mag.pop_back());
        wr_done = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        for (int i = SCAN_LO; i <= SCAN_HI; i++) mem[i] = DATA_W'($urandom);
        capture(9, 1'b0);

        check("queue_empty", q_addr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
